// File: rtl/wts_pkg.sv
// Shared constants and types for the wave-table sound (WTS) core.
package wts_pkg;

  localparam int unsigned WTS_RAM_ADDR_W = 9;
  localparam int unsigned WTS_RAM_DATA_W = 8;
  localparam int unsigned WTS_RAM_DEPTH  = 384;

  typedef logic [WTS_RAM_ADDR_W-1:0] wts_ram_addr_t;
  typedef logic [WTS_RAM_DATA_W-1:0] wts_sample_t;

endpackage

// File: rtl/wts_wave_ram.sv
// Single-port wave-table sample RAM (12 channels x 32 samples), read-first,
// with a registered output that is cleared by an asynchronous reset.
module wts_wave_ram
  import wts_pkg::*;
#(
  parameter int unsigned ADDR_W = WTS_RAM_ADDR_W,
  parameter int unsigned DATA_W = WTS_RAM_DATA_W,
  parameter int unsigned DEPTH  = WTS_RAM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sram_we,
  input  logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_d,
  output logic [DATA_W-1:0] sram_q
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  // Compare one bit wider than the address so DEPTH == 2**ADDR_W also works.
  assign in_range = {1'b0, sram_a} < (ADDR_W+1)'(DEPTH);

  // Array has no reset so it stays inferable as block RAM.
  always_ff @(posedge clk) begin
    if (!reset && sram_we && in_range) begin
      mem[sram_a] <= sram_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_q <= '0;
    end else if (in_range) begin
      sram_q <= mem[sram_a];
    end else begin
      sram_q <= '0;
    end
  end

endmodule

// File: tb/tb_wts_wave_ram.sv
// Directed self-checking bench for wts_wave_ram.
module tb_wts_wave_ram;
  import wts_pkg::*;

  logic          clk;
  logic          reset;
  logic          sram_we;
  wts_ram_addr_t sram_a;
  wts_sample_t   sram_d;
  wts_sample_t   sram_q;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  wts_wave_ram #(
    .ADDR_W (WTS_RAM_ADDR_W),
    .DATA_W (WTS_RAM_DATA_W),
    .DEPTH  (WTS_RAM_DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sram_we (sram_we),
    .sram_a  (sram_a),
    .sram_d  (sram_d),
    .sram_q  (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input wts_sample_t obs, input wts_sample_t exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one access, then return 1 time unit after the sampling edge.
  task automatic step(input logic we, input int a, input wts_sample_t d);
    sram_we = we;
    sram_a  = 9'(a);
    sram_d  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    sram_we = 1'b0;
    sram_a  = '0;
    sram_d  = '0;
    #1;
    check("reset_q", sram_q, 8'h00);
    @(posedge clk);
    #1;
    check("reset_q_after_edge", sram_q, 8'h00);
    reset = 1'b0;

    // Fill, one write per cycle.
    for (int i = 0; i < 384; i++) begin
      step(1'b1, i, 8'((i + 100) & 255));
    end

    // Pipelined readback with random don't-care write data.
    for (int i = 0; i < 384; i++) begin
      step(1'b0, i, 8'($urandom_range(0, 255)));
      check($sformatf("fill_rd_%0d", i), sram_q, 8'((i + 100) & 255));
    end

    // Latency: data for address sampled at edge N holds until edge N+1.
    step(1'b0, 10, 8'h00);
    check("lat_a10", sram_q, 8'd110);
    sram_a = 9'd11;
    #3;
    check("lat_a10_hold", sram_q, 8'd110);
    @(posedge clk);
    #1;
    check("lat_a11", sram_q, 8'd111);

    // Read-first on write.
    step(1'b1, 5, 8'hA5);
    check("rf_old", sram_q, 8'd105);
    step(1'b0, 5, 8'h00);
    check("rf_new", sram_q, 8'hA5);

    // Out of range: writes ignored, reads return zero, no aliasing.
    step(1'b1, 384, 8'h5A);
    check("oor_wr384_q", sram_q, 8'h00);
    step(1'b1, 511, 8'h5A);
    check("oor_wr511_q", sram_q, 8'h00);
    step(1'b0, 384, 8'h00);
    check("oor_rd384", sram_q, 8'h00);
    step(1'b0, 511, 8'h00);
    check("oor_rd511", sram_q, 8'h00);
    step(1'b0, 0, 8'h00);
    check("oor_mem0", sram_q, 8'd100);
    step(1'b0, 127, 8'h00);
    check("oor_mem127", sram_q, 8'd227);
    step(1'b0, 128, 8'h00);
    check("oor_mem128", sram_q, 8'd228);
    step(1'b0, 255, 8'h00);
    check("oor_mem255", sram_q, 8'd99);

    // Reset asserted between edges in a read stream.
    step(1'b0, 200, 8'h00);
    check("rst_pre", sram_q, 8'd44);
    sram_a = 9'd201;
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_clear", sram_q, 8'h00);
    step(1'b1, 200, 8'hFF);
    check("rst_hold_q0", sram_q, 8'h00);
    step(1'b1, 201, 8'hEE);
    check("rst_hold_q1", sram_q, 8'h00);
    reset = 1'b0;
    step(1'b0, 200, 8'h00);
    check("rst_retain200", sram_q, 8'd44);
    step(1'b0, 201, 8'h00);
    check("rst_retain201", sram_q, 8'd45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wts_wave_ram.md
Name: wts_wave_ram

Overview:
- Single-port synchronous SRAM holding wave-table sample data for the wave-table sound (WTS) core.
- 384 bytes: 12 channels × 32 samples × 8 bit.
- The register/CPU-write side and the tone-generator read side share one port, time-multiplexed by the parent.
- Registered read data; one access (read or write) per clock.

Parameters:
- ADDR_W, 9, address width in bits.
- DATA_W, 8, data width in bits.
- DEPTH, 384, number of implemented words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sram_we  input  1  write enable; 1 = write sram_d to sram_a this cycle.
- sram_a  input  ADDR_W  word address (0..DEPTH-1 valid).
- sram_d  input  DATA_W  write data.
- sram_q  output  DATA_W  registered read data.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset:
  - Asserting reset clears sram_q to 8'h00 immediately, independent of clk.
  - Array contents are not cleared; they hold their previous value.
  - After power-up the array is undefined, and the testbench must not rely on any initial value.
  - While reset is high, writes are ignored and sram_q holds 8'h00.
- Write:
  - At a rising clk edge with sram_we=1 and sram_a<DEPTH, mem[sram_a] <= sram_d.
  - Back-to-back writes at one per cycle are supported, with no gaps.
- Read:
  - At every rising clk edge with sram_we=0, sram_q <= mem[sram_a] (sram_a < DEPTH).
  - Latency is 1 cycle: an address sampled at edge N is on sram_q after edge N, stable until edge N+1.
  - Reads are pipelined at one per cycle.
- Write cycle output: when sram_we=1, sram_q <= old content of mem[sram_a] (read-first). The newly written value is visible on the next read of that address.
- Out of range (sram_a ≥ DEPTH, i.e. 384..511):
  - Writes are ignored, with no aliasing into 0..383.
  - Reads load sram_q <= 8'h00.
- Data is stored and returned as raw 8-bit values; no transformation is applied.
- Inputs are sampled only at rising clk edges; sram_d is don't-care when sram_we=0.
- Implementation: behavioural array inferable as block RAM, with a separate output register carrying the async reset.

Decomposition:
- Shared package wts_pkg holds:
  - constants WTS_RAM_ADDR_W=9, WTS_RAM_DATA_W=8, WTS_RAM_DEPTH=384;
  - typedefs wts_ram_addr_t (logic [8:0]) and wts_sample_t (logic [7:0]).
- No sub-module: the array and the output register live in one module.
- The testbench-side reference model (an associative array) belongs in the testbench, not the RTL.

Test Plan:
- Fill/readback:
  - write mem[i] = (i+100)&255 for i=0..383, one write per consecutive cycle;
  - then read i=0..383 with random sram_d and sram_we=0;
  - sram_q equals (i+100)&255 one cycle after each address is sampled (e.g. a=0 -> 100, a=155 -> 255, a=156 -> 0, a=383 -> 227).
- Read latency:
  - read a=10 at edge N, then a=11 at edge N+1;
  - sram_q=110 between edges N and N+1, and 111 after edge N+1 (pipelined, one per cycle).
- Read-first:
  - with mem[5]=105, write sram_d=8'hA5 to a=5;
  - sram_q=105 after the write edge;
  - a following read of a=5 returns 8'hA5.
- Out of range:
  - write 8'h5A to a=384 and a=511;
  - reads of those addresses give 8'h00;
  - mem[0] and mem[127] are unchanged (100, 227).
- Reset:
  - assert reset mid-read-stream, between clock edges; sram_q becomes 8'h00 before the next edge;
  - writes with reset=1 have no effect;
  - after release, reading a=200 returns 44 (contents retained).
